// File: rtl/fm_dsp_pkg.sv
// fm_dsp_pkg -- shared definitions for the FM DSP filters
// (pre-emphasis IIR, de-emphasis IIR, FIR filters).
//
// Contents:
//   FM_DW        : sample/coefficient width the helper functions are sized for
//   QBITS        : fractional bits of the Q-format coefficients
//   iir_state_e  : sequencer states of the single-multiplier IIR filters
//   mul_q()      : signed full-width multiply, arithmetic shift right (floor),
//                  result truncated to FM_DW+2 bits
//   sat_dw()     : clamp an FM_DW+2-bit accumulator to FM_DW bits
package fm_dsp_pkg;

  localparam int FM_DW = 32;
  localparam int QBITS = 10;

  typedef enum logic [2:0] {
    READ  = 3'd0,
    MAC0  = 3'd1,
    MAC1  = 3'd2,
    MAC2  = 3'd3,
    WRITE = 3'd4
  } iir_state_e;

  // Product of two Q-format values. The arithmetic shift floors toward
  // minus infinity; the two guard bits above FM_DW leave room for a
  // three-term sum without wrap.
  function automatic logic signed [FM_DW+1:0] mul_q(
    input logic signed [FM_DW-1:0] a,
    input logic signed [FM_DW-1:0] b,
    input int                      shift
  );
    logic signed [2*FM_DW-1:0] p;
    p = (2*FM_DW)'(a) * (2*FM_DW)'(b);
    p = p >>> shift;
    return p[FM_DW+1:0];
  endfunction

  // Clamp to [most negative, most positive] FM_DW-bit value. The value fits
  // when the top three bits (two guard bits plus sign) all agree.
  function automatic logic signed [FM_DW-1:0] sat_dw(
    input logic signed [FM_DW+1:0] v
  );
    logic [2:0] top;
    top = v[FM_DW+1:FM_DW-1];
    if ((&top) || !(|top)) return v[FM_DW-1:0];
    else if (v[FM_DW+1])   return {1'b1, {(FM_DW-1){1'b0}}};
    else                   return {1'b0, {(FM_DW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/preemph_iir.sv
// preemph_iir -- first-order pre-emphasis IIR for the FM transmit path.
//   y[n] = B0*x[n] + B1*x[n-1] + A1*y[n-1]   (Q-format coefficients)
// One sample at a time: pop upstream FWFT FIFO, three MAC steps on a single
// shared multiplier, push the saturated result downstream.
//
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous, active-high
//   in_dout    : upstream FIFO head, valid when in_empty = 0
//   in_empty   : upstream FIFO empty
//   in_rd_en   : pop upstream FIFO this cycle
//   out_din    : result to downstream FIFO (0 outside WRITE)
//   out_wr_en  : push downstream FIFO this cycle
//   out_full   : downstream FIFO full
//
// The package helpers are sized for FM_DW; DATA_WIDTH must stay equal to it.
module preemph_iir
  import fm_dsp_pkg::*;
#(
  parameter int                    DATA_WIDTH = FM_DW,
  parameter int                    QBITS      = fm_dsp_pkg::QBITS,
  parameter logic [DATA_WIDTH-1:0] B0         = 32'h0000_0400,
  parameter logic [DATA_WIDTH-1:0] B1         = 32'hFFFF_FD9A,
  parameter logic [DATA_WIDTH-1:0] A1         = 32'hFFFF_FF33
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_wr_en,
  input  logic                  out_full
);

  iir_state_e                   state_q, state_d;
  logic signed [DATA_WIDTH+1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic signed [DATA_WIDTH-1:0] x1_q, x1_d;
  logic signed [DATA_WIDTH-1:0] y1_q, y1_d;

  logic signed [DATA_WIDTH-1:0] mul_a, mul_b;
  logic signed [DATA_WIDTH+1:0] prod;
  logic signed [DATA_WIDTH-1:0] y_sat;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    x_d       = x_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    out_din   = '0;
    mul_a     = '0;
    mul_b     = '0;

    // Operand mux in front of the one shared multiplier.
    unique case (state_q)
      MAC0:    begin mul_a = B0; mul_b = x_q;  end
      MAC1:    begin mul_a = B1; mul_b = x1_q; end
      MAC2:    begin mul_a = A1; mul_b = y1_q; end
      default: ;
    endcase

    prod  = mul_q(mul_a, mul_b, QBITS);
    y_sat = sat_dw(acc_q);

    unique case (state_q)
      READ: begin
        // Gated by reset so the FIFO is never popped while held in reset.
        if (!in_empty && !reset) begin
          in_rd_en = 1'b1;
          x_d      = in_dout;
          acc_d    = '0;
          state_d  = MAC0;
        end
      end
      MAC0: begin
        acc_d   = acc_q + prod;
        state_d = MAC1;
      end
      MAC1: begin
        acc_d   = acc_q + prod;
        state_d = MAC2;
      end
      MAC2: begin
        acc_d   = acc_q + prod;
        state_d = WRITE;
      end
      WRITE: begin
        out_din = y_sat;
        // History moves only on the push, so backpressure leaves it intact.
        if (!out_full) begin
          out_wr_en = 1'b1;
          x1_d      = x_q;
          y1_d      = y_sat;
          state_d   = READ;
        end
      end
      default: state_d = READ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= READ;
      acc_q   <= '0;
      x_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
    end
  end

endmodule

// File: tb/tb_preemph_iir.sv
// tb_preemph_iir -- directed self-checking bench for preemph_iir.
// Two instances share the input stimulus: dut_m with default coefficients
// and dut_s with B0 = 2.0 to drive the accumulator into saturation.
module tb_preemph_iir;

  logic        clock;
  logic        reset;
  logic [31:0] in_dout;
  logic        in_empty;
  logic        out_full;

  logic        in_rd_en_m, out_wr_en_m;
  logic [31:0] out_din_m;
  logic        in_rd_en_s, out_wr_en_s;
  logic [31:0] out_din_s;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  preemph_iir dut_m (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en_m),
    .out_din   (out_din_m),
    .out_wr_en (out_wr_en_m),
    .out_full  (out_full)
  );

  preemph_iir #(.B0(32'h0000_0800)) dut_s (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en_s),
    .out_din   (out_din_s),
    .out_wr_en (out_wr_en_s),
    .out_full  (out_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference arithmetic in 64-bit signed integers.
  function automatic longint ref_mul(input longint c, input longint d);
    longint p;
    p = c * d;
    return p >>> 10;
  endfunction

  function automatic longint ref_sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic apply_reset();
    in_empty = 1'b1;
    out_full = 1'b0;
    in_dout  = '0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Presents one sample, waits for its push. hold = cycles out_full is kept
  // high once WRITE is reached. While the sample is in flight in_empty stays
  // low with a garbage head, which the DUT must ignore.
  task automatic run_sample(input logic [31:0] x, input int hold,
                            output logic [31:0] y, output logic [31:0] ys,
                            output int lat, output bit ok, output bit stable,
                            output bit stray_rd, output time t_push);
    bit          popped;
    int          held;
    logic [31:0] first;
    ok = 1'b0; stable = 1'b1; stray_rd = 1'b0; lat = 0;
    y = '0; ys = '0; held = 0; first = '0; t_push = 0; popped = 1'b0;
    for (int i = 0; i < 20 && !popped; i++) begin
      @(negedge clock);
      in_dout  = x;
      in_empty = 1'b0;
      #1;
      popped = in_rd_en_m;
    end
    if (!popped) begin
      in_empty = 1'b1;
      return;
    end
    out_full = (hold > 0);
    @(posedge clock);
    #1;
    in_dout = 32'hDEAD_BEEF;
    for (int c = 1; c <= 60 && !ok; c++) begin
      @(negedge clock);
      if (held == hold) out_full = 1'b0;
      #1;
      if (in_rd_en_m) stray_rd = 1'b1;
      if (out_wr_en_m) begin
        ok = 1'b1; lat = c; y = out_din_m; ys = out_din_s; t_push = $time;
        in_empty = 1'b1;
        in_dout  = '0;
      end else if (c >= 4) begin
        if (c == 4) first = out_din_m;
        else if (out_din_m !== first) stable = 1'b0;
        held++;
      end
    end
    in_empty = 1'b1;
    out_full = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    in_empty = 1'b0;
    out_full = 1'b0;
    in_dout  = 32'h0000_1234;
    #3;
    tests_run++;
    if ({in_rd_en_m, out_wr_en_m, out_din_m, in_rd_en_s, out_wr_en_s, out_din_s} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rd=%b wr=%b din=%h (sat rd=%b wr=%b din=%h), required all 0",
               in_rd_en_m, out_wr_en_m, out_din_m, in_rd_en_s, out_wr_en_s, out_din_s);
    end
    repeat (2) @(negedge clock);
    apply_reset();
  endtask

  task automatic test_impulse();
    logic [31:0] exp_y [3] = '{32'h0000_0400, 32'hFFFF_FCCD, 32'h0000_00A3};
    logic [31:0] xin   [3] = '{32'h0000_0400, 32'h0, 32'h0};
    logic [31:0] y, ys;
    int lat; bit ok, stable, stray; time tp;
    for (int i = 0; i < 3; i++) begin
      run_sample(xin[i], 0, y, ys, lat, ok, stable, stray, tp);
      tests_run++;
      if (!ok || y !== exp_y[i]) begin
        tests_failed++;
        $display("FAIL impulse_%0d: got %h (pushed=%b), required %h", i, y, ok, exp_y[i]);
      end
      tests_run++;
      if (lat != 4 || stray) begin
        tests_failed++;
        $display("FAIL impulse_latency_%0d: latency %0d stray_rd=%b, required 4 and 0", i, lat, stray);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] y, ys;
    int lat; bit ok, stable, stray; time tp;
    apply_reset();
    run_sample(32'h0000_0400, 0, y, ys, lat, ok, stable, stray, tp);
    run_sample(32'h0, 10, y, ys, lat, ok, stable, stray, tp);
    tests_run++;
    if (!ok || y !== 32'hFFFF_FCCD) begin
      tests_failed++;
      $display("FAIL backpressure_value: got %h, required fffffccd", y);
    end
    tests_run++;
    if (lat != 14 || !stable) begin
      tests_failed++;
      $display("FAIL backpressure_hold: push after %0d cycles stable=%b, required 14 and 1", lat, stable);
    end
    @(negedge clock);
    #1;
    tests_run++;
    if (out_wr_en_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_single_push: out_wr_en=%b after push, required 0", out_wr_en_m);
    end
    run_sample(32'h0, 0, y, ys, lat, ok, stable, stray, tp);
    tests_run++;
    if (!ok || y !== 32'h0000_00A3) begin
      tests_failed++;
      $display("FAIL backpressure_history: got %h, required 000000a3", y);
    end
  endtask

  task automatic test_empty();
    logic [31:0] y, ys;
    int lat; bit ok, stable, stray, bad; time tp;
    apply_reset();
    bad = 1'b0;
    in_dout = 32'h0BAD_0BAD;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      if (in_rd_en_m !== 1'b0 || out_wr_en_m !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL empty_idle: activity seen while upstream empty, required none");
    end
    run_sample(32'h0000_0400, 0, y, ys, lat, ok, stable, stray, tp);
    tests_run++;
    if (!ok || y !== 32'h0000_0400 || lat != 4 || stray) begin
      tests_failed++;
      $display("FAIL empty_then_sample: got %h latency %0d stray_rd=%b, required 00000400 4 0",
               y, lat, stray);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] xin   [3] = '{32'h5000_0000, 32'hB000_0000, 32'h0};
    logic [31:0] exp_y [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h4998_0000};
    logic [31:0] y, ys;
    int lat; bit ok, stable, stray; time tp;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      run_sample(xin[i], 0, y, ys, lat, ok, stable, stray, tp);
      tests_run++;
      if (!ok || ys !== exp_y[i]) begin
        tests_failed++;
        $display("FAIL saturation_%0d: got %h, required %h", i, ys, exp_y[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [31:0] exp_y [3] = '{32'h0000_0400, 32'hFFFF_FCCD, 32'h0000_00A3};
    logic [31:0] xin   [3] = '{32'h0000_0400, 32'h0, 32'h0};
    logic [31:0] y, ys;
    int lat; bit ok, stable, stray, pushed; time tp;
    apply_reset();
    @(negedge clock);
    in_dout  = 32'h0000_1234;
    in_empty = 1'b0;
    @(posedge clock);
    #1;
    in_empty = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({in_rd_en_m, out_wr_en_m, out_din_m} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_mac_outputs: rd=%b wr=%b din=%h, required all 0",
               in_rd_en_m, out_wr_en_m, out_din_m);
    end
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    pushed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      if (out_wr_en_m) pushed = 1'b1;
    end
    tests_run++;
    if (pushed) begin
      tests_failed++;
      $display("FAIL reset_mid_mac_no_push: push seen after reset, required none");
    end
    for (int i = 0; i < 3; i++) begin
      run_sample(xin[i], 0, y, ys, lat, ok, stable, stray, tp);
      tests_run++;
      if (!ok || y !== exp_y[i]) begin
        tests_failed++;
        $display("FAIL reset_impulse_%0d: got %h, required %h", i, y, exp_y[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, ys, e_m, e_s;
    longint xs, m_x1, m_y1, s_y1, v;
    int lat, bad_gap; bit ok, stable, stray; time tp, tp_prev;
    apply_reset();
    m_x1 = 0; m_y1 = 0; s_y1 = 0; bad_gap = 0; tp_prev = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 0)      x = 32'h7FFF_FFFF;
      else if (i == 1) x = 32'h8000_0000;
      else             x = $urandom;
      xs = longint'($signed(x));
      v  = ref_sat(ref_mul(1024, xs) + ref_mul(-614, m_x1) + ref_mul(-205, m_y1));
      e_m = v[31:0];
      m_y1 = v;
      v  = ref_sat(ref_mul(2048, xs) + ref_mul(-614, m_x1) + ref_mul(-205, s_y1));
      e_s = v[31:0];
      s_y1 = v;
      m_x1 = xs;
      run_sample(x, 0, y, ys, lat, ok, stable, stray, tp);
      tests_run++;
      if (!ok || y !== e_m || ys !== e_s) begin
        tests_failed++;
        $display("FAIL stream_%0d: in %h got %h/%h, required %h/%h", i, x, y, ys, e_m, e_s);
      end
      if (i > 0 && (tp - tp_prev) != 50) bad_gap++;
      tp_prev = tp;
    end
    tests_run++;
    if (bad_gap != 0) begin
      tests_failed++;
      $display("FAIL stream_rate: %0d push gaps differ from 5 cycles, required 0", bad_gap);
    end
  endtask

  initial begin
    in_dout  = '0;
    in_empty = 1'b1;
    out_full = 1'b0;
    test_reset();
    test_impulse();
    test_backpressure();
    test_empty();
    test_saturation();
    test_reset_mid_mac();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
